// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV32I subset core (add/sub/and/or/slt, addi/slti/andi/ori, lw/sw/beq)
// plus custom NOR/NORI, with a built-in 64-word program ROM and 64-word data RAM.
module riscv_single_cycle_core (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Result
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_NORI   = 7'b0001011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  // Program ROM; every word not listed reads 0, which decodes as a NOP.
  function automatic logic [31:0] rom_word(input logic [5:0] addr);
    logic [31:0] w;
    w = 32'h0;
    case (addr)
      6'd0:  w = enc_r(F7_BASE, 5'd0, 5'd0, F3_AND, 5'd1);
      6'd1:  w = enc_i(12'd1, 5'd0, F3_ADD, 5'd1, OP_I);
      6'd2:  w = enc_i(12'd2, 5'd0, F3_ADD, 5'd2, OP_I);
      6'd3:  w = enc_i(12'd4, 5'd0, F3_ADD, 5'd3, OP_I);
      6'd4:  w = enc_i(12'd5, 5'd0, F3_ADD, 5'd4, OP_I);
      6'd5:  w = enc_i(12'd7, 5'd0, F3_ADD, 5'd5, OP_I);
      6'd6:  w = enc_i(12'd8, 5'd0, F3_ADD, 5'd6, OP_I);
      6'd7:  w = enc_i(12'd11, 5'd0, F3_ADD, 5'd7, OP_I);
      6'd8:  w = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd8);
      6'd9:  w = enc_r(F7_ALT, 5'd5, 5'd4, F3_ADD, 5'd9);
      6'd10: w = enc_r(F7_BASE, 5'd2, 5'd9, F3_ADD, 5'd10);
      6'd11: w = enc_r(F7_BASE, 5'd3, 5'd1, F3_OR, 5'd11);
      6'd12: w = enc_r(F7_BASE, 5'd1, 5'd9, F3_SLT, 5'd12);
      6'd13: w = enc_r(F7_ALT, 5'd0, 5'd7, F3_OR, 5'd13);
      6'd14: w = enc_i(12'h4D2, 5'd9, F3_AND, 5'd14, OP_I);
      6'd15: w = enc_i(12'h8D2, 5'd4, F3_OR, 5'd15, OP_I);
      6'd16: w = enc_r(F7_BASE, 5'd14, 5'd15, F3_SLT, 5'd16);
      6'd17: w = enc_i(12'h001, 5'd14, F3_OR, 5'd17, OP_NORI);
      6'd18: w = enc_s(12'h030, 5'd11, 5'd0);
      6'd19: w = enc_i(12'h030, 5'd0, F3_W, 5'd18, OP_LOAD);
      6'd20: w = enc_b(13'h0, 5'd0, 5'd0);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] dmem_q [64];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] a, b, alu;
  logic        reg_we, mem_we, is_load, br_taken;
  logic [31:0] wb_data;

  assign instr  = rom_word(pc_q[7:2]);
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign a = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
  assign b = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];

  // Anything not decoded below leaves all enables low and alu at 0, i.e. a NOP.
  always_comb begin
    alu      = 32'h0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    is_load  = 1'b0;
    br_taken = 1'b0;
    case (opcode)
      OP_R: begin
        reg_we = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: alu = a + b;
          {F7_ALT,  F3_ADD}: alu = a - b;
          {F7_BASE, F3_AND}: alu = a & b;
          {F7_BASE, F3_OR}:  alu = a | b;
          {F7_BASE, F3_SLT}: alu = {31'b0, $signed(a) < $signed(b)};
          {F7_ALT,  F3_OR}:  alu = ~(a | b);
          default:           reg_we = 1'b0;
        endcase
      end
      OP_I: begin
        reg_we = 1'b1;
        case (funct3)
          F3_ADD:  alu = a + imm_i;
          F3_SLT:  alu = {31'b0, $signed(a) < $signed(imm_i)};
          F3_AND:  alu = a & imm_i;
          F3_OR:   alu = a | imm_i;
          default: reg_we = 1'b0;
        endcase
      end
      OP_NORI: if (funct3 == F3_OR) begin
        alu    = ~(a | imm_i);
        reg_we = 1'b1;
      end
      OP_LOAD: if (funct3 == F3_W) begin
        alu     = a + imm_i;
        reg_we  = 1'b1;
        is_load = 1'b1;
      end
      OP_STORE: if (funct3 == F3_W) begin
        alu    = a + imm_s;
        mem_we = 1'b1;
      end
      OP_BRANCH: if (funct3 == 3'b000) begin
        alu      = a - b;
        br_taken = (alu == 32'h0);
      end
      default: ;
    endcase
  end

  assign wb_data = is_load ? dmem_q[alu[7:2]] : alu;
  assign pc_d    = br_taken ? pc_q + imm_b : pc_q + 32'd4;
  assign Result  = alu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (reg_we && rd != 5'd0) rf_q[rd] <= wb_data;
    end
  end

  // Data RAM has no reset so its contents survive a mid-program reset.
  always_ff @(posedge clk) begin
    if (mem_we && reset) dmem_q[alu[7:2]] <= b;
  end

endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Bench for riscv_single_cycle_core: expected-sequence table, hand-written reset/halt
// sequences, and randomized reset timing checked against an instruction-level model.
module tb_riscv_single_cycle_core;

  logic        clk;
  logic        reset;
  logic [31:0] Result;

  riscv_single_cycle_core dut (
    .clk   (clk),
    .reset (reset),
    .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum {I_NOP, I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_NOR,
                I_ADDI, I_SLTI, I_ANDI, I_ORI, I_NORI, I_LW, I_SW, I_BEQ} op_e;
  typedef struct {
    op_e op;
    int  rd;
    int  rs1;
    int  rs2;
    int  imm;
  } ins_t;
  typedef struct {
    int          word;
    logic [31:0] result;
  } vec_t;

  ins_t        prog [64];
  vec_t        vecs [21];
  logic [31:0] m_regs [32];
  logic [31:0] m_ram [64];
  logic [31:0] m_pc;

  function automatic int sx12(input int v);
    return (v & 'h800) != 0 ? v - 4096 : v;
  endfunction

  task automatic set_ins(input int w, input op_e op, input int rd, input int rs1,
                         input int rs2, input int imm);
    prog[w].op  = op;
    prog[w].rd  = rd;
    prog[w].rs1 = rs1;
    prog[w].rs2 = rs2;
    prog[w].imm = sx12(imm);
  endtask

  function automatic logic [31:0] model_result();
    ins_t        ins;
    logic [31:0] x, y, k;
    ins = prog[m_pc[7:2]];
    x = m_regs[ins.rs1];
    y = m_regs[ins.rs2];
    k = 32'(ins.imm);
    case (ins.op)
      I_ADD:  return x + y;
      I_SUB:  return x - y;
      I_AND:  return x & y;
      I_OR:   return x | y;
      I_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      I_NOR:  return ~(x | y);
      I_ADDI: return x + k;
      I_SLTI: return ($signed(x) < $signed(k)) ? 32'd1 : 32'd0;
      I_ANDI: return x & k;
      I_ORI:  return x | k;
      I_NORI: return ~(x | k);
      I_LW:   return x + k;
      I_SW:   return x + k;
      I_BEQ:  return x - y;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    ins_t        ins;
    logic [31:0] r;
    ins = prog[m_pc[7:2]];
    r = model_result();
    case (ins.op)
      I_NOP: ;
      I_SW:  m_ram[r[7:2]] = m_regs[ins.rs2];
      I_BEQ: ;
      I_LW:  if (ins.rd != 0) m_regs[ins.rd] = m_ram[r[7:2]];
      default: if (ins.rd != 0) m_regs[ins.rd] = r;
    endcase
    if (ins.op == I_BEQ && r == 32'h0) m_pc = m_pc + 32'(ins.imm);
    else m_pc = m_pc + 32'd4;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.rf_q[i], m_regs[i]);
  endtask

  // Called at a falling edge: compare against the model, then let one instruction execute.
  task automatic cycle_check(input string tag);
    #1;
    check({tag, "_result"}, Result, model_result());
    check({tag, "_pc"}, dut.pc_q, m_pc);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int d;
    for (int i = 0; i < 64; i++) begin
      set_ins(i, I_NOP, 0, 0, 0, 0);
      m_ram[i] = 32'h0;
    end
    set_ins(0,  I_AND,  1, 0, 0, 0);
    set_ins(1,  I_ADDI, 1, 0, 0, 1);
    set_ins(2,  I_ADDI, 2, 0, 0, 2);
    set_ins(3,  I_ADDI, 3, 0, 0, 4);
    set_ins(4,  I_ADDI, 4, 0, 0, 5);
    set_ins(5,  I_ADDI, 5, 0, 0, 7);
    set_ins(6,  I_ADDI, 6, 0, 0, 8);
    set_ins(7,  I_ADDI, 7, 0, 0, 11);
    set_ins(8,  I_ADD,  8, 1, 2, 0);
    set_ins(9,  I_SUB,  9, 4, 5, 0);
    set_ins(10, I_ADD, 10, 9, 2, 0);
    set_ins(11, I_OR,  11, 1, 3, 0);
    set_ins(12, I_SLT, 12, 9, 1, 0);
    set_ins(13, I_NOR, 13, 7, 0, 0);
    set_ins(14, I_ANDI, 14, 9, 0, 'h4D2);
    set_ins(15, I_ORI,  15, 4, 0, 'h8D2);
    set_ins(16, I_SLT,  16, 15, 14, 0);
    set_ins(17, I_NORI, 17, 14, 0, 1);
    set_ins(18, I_SW,    0, 0, 11, 'h30);
    set_ins(19, I_LW,   18, 0, 0, 'h30);
    set_ins(20, I_BEQ,   0, 0, 0, 0);

    vecs[0]  = '{0,  32'h0};        vecs[1]  = '{1,  32'h1};
    vecs[2]  = '{2,  32'h2};        vecs[3]  = '{3,  32'h4};
    vecs[4]  = '{4,  32'h5};        vecs[5]  = '{5,  32'h7};
    vecs[6]  = '{6,  32'h8};        vecs[7]  = '{7,  32'hb};
    vecs[8]  = '{8,  32'h3};        vecs[9]  = '{9,  32'hfffffffe};
    vecs[10] = '{10, 32'h0};        vecs[11] = '{11, 32'h5};
    vecs[12] = '{12, 32'h1};        vecs[13] = '{13, 32'hfffffff4};
    vecs[14] = '{14, 32'h4d2};      vecs[15] = '{15, 32'hfffff8d7};
    vecs[16] = '{16, 32'h1};        vecs[17] = '{17, 32'hfffffb2c};
    vecs[18] = '{18, 32'h30};       vecs[19] = '{19, 32'h30};
    vecs[20] = '{20, 32'h0};

    // Reset held for two cycles.
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_pc", dut.pc_q, 32'h0);
    check("reset_result", Result, 32'h0);
    check_regs("reset");

    // Full program against the expected sequence table.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      $display("word %0d pc=%h result=%h", vecs[i].word, dut.pc_q, Result);
      check($sformatf("seq_w%0d", i), Result, vecs[i].result);
      check($sformatf("seq_pc%0d", i), dut.pc_q, 32'(vecs[i].word * 4));
      if (i == 1) check("x0_after_w0", dut.rf_q[0], 32'h0);
      if (i == 10) check("x9_before_w10", dut.rf_q[9], 32'hfffffffe);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    #1;
    check("roundtrip_x18", dut.rf_q[18], 32'h5);
    check("roundtrip_ram12", dut.dmem_q[12], 32'h5);
    check("halt_result", Result, vecs[20].result);
    check("halt_pc", dut.pc_q, 32'h50);

    // Halt: ten more cycles, nothing moves.
    @(negedge clk);
    for (int i = 0; i < 10; i++) cycle_check($sformatf("halt%0d", i));
    check("halt_pc_final", dut.pc_q, 32'h50);
    check_regs("halt");
    check("halt_ram12", dut.dmem_q[12], 32'h5);

    // Mid-run reset at word 9.
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) cycle_check($sformatf("pre_mid%0d", i));
    #1;
    check("mid_w9_result", Result, 32'hfffffffe);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_reset_result", Result, 32'h0);
    check("mid_reset_pc", dut.pc_q, 32'h0);
    check_regs("mid_reset");
    @(negedge clk);
    check("mid_ram12_kept", dut.dmem_q[12], 32'h5);
    reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1;
      $display("replay word %0d result=%h", i, Result);
      check($sformatf("replay_w%0d", i), Result, vecs[i].result);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    check("replay_ram12_before_w18", dut.dmem_q[12], 32'h5);

    // Randomized run lengths and asynchronous reset timing.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 30);
      for (int c = 0; c < n; c++) cycle_check($sformatf("rnd%0d_c%0d", t, c));
      d = $urandom_range(1, 3);
      #(d);
      reset = 1'b0;
      model_reset();
      #1;
      check($sformatf("rnd%0d_async_result", t), Result, 32'h0);
      check($sformatf("rnd%0d_async_pc", t), dut.pc_q, 32'h0);
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      reset = 1'b1;
      $display("trial %0d ran %0d cycles then reset", t, n);
    end
    for (int c = 0; c < 25; c++) cycle_check($sformatf("final_c%0d", c));
    check_regs("final");
    check("final_ram12", dut.dmem_q[12], m_ram[12]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_single_cycle_core.md
# riscv_single_cycle_core

Single-cycle 32-bit RISC-V subset processor (RV32I base plus two custom logic ops, NOR and NORI) with on-chip instruction ROM, register file and data RAM. It executes one instruction per clock from a fixed built-in program. It exposes only the ALU result of the instruction currently at the PC, for bring-up and self-checking benches. It is the top of the CPU datapath; there are no external bus ports.

## Interface
- No parameters. ROM and RAM are fixed at 64 words each.
- clk  input  1  rising-edge clock. One clock domain; reset is asynchronous and active-low.
- reset  input  1  asynchronous, active-low reset.
- Result  output  32  combinational ALU output of the instruction at the current PC.

## Operation
- Fetch:
  - PC is 32-bit and resets to 0.
  - ROM is read combinationally at PC[7:2].
  - Next PC is PC+4, or PC+imm_B when a beq is taken.
- Register file: 32x32, two combinational read ports, one write port written on the rising edge. x0 reads 0 and ignores writes.
- Supported instructions (standard RV32I encoding unless noted):
  - R-type, opcode 0110011: add, sub, and, or, slt (signed).
  - NOR (custom R-type): opcode 0110011, funct3=110, funct7=0100000. rd = ~(rs1|rs2).
  - I-type, opcode 0010011: addi, slti, andi, ori.
  - NORI (custom): opcode 0001011, funct3=110. rd = ~(rs1|sext(imm)).
  - Memory: lw (0000011), sw (0100011).
  - Branch: beq (1100011).
- Immediates: I and S immediates are 12-bit, sign-extended. B immediate is 13-bit, sign-extended, with LSB 0.
- ALU result:
  - Arithmetic wraps modulo 2^32.
  - slt yields 1 or 0.
  - lw and sw compute the address rs1+imm.
  - beq computes rs1-rs2; the branch is taken when that is zero.
- Result always equals the ALU output, including for sw, lw and beq.
- Data RAM: 64 words, indexed by address[7:2].
  - Written on the rising edge when sw.
  - Read combinationally for lw.
  - Not cleared by reset.
- Undefined opcodes (including all-zero words) behave as NOP: no register or memory write, PC+4, Result 0.
- Built-in program, words 0-20, with the Result value at each step:
  - 0: and x1,x0,x0 → 0
  - 1: addi x1,x0,1 → 1
  - 2: addi x2,x0,2 → 2
  - 3: addi x3,x0,4 → 4
  - 4: addi x4,x0,5 → 5
  - 5: addi x5,x0,7 → 7
  - 6: addi x6,x0,8 → 8
  - 7: addi x7,x0,11 → 0x0000000b
  - 8: add x8,x1,x2 → 3
  - 9: sub x9,x4,x5 → 0xfffffffe
  - 10: add x10,x9,x2 → 0
  - 11: or x11,x1,x3 → 5
  - 12: slt x12,x9,x1 → 1
  - 13: nor x13,x7,x0 → 0xfffffff4
  - 14: andi x14,x9,0x4D2 → 0x000004d2
  - 15: ori x15,x4,0x8D2 → 0xfffff8d7
  - 16: slt x16,x15,x14 → 1
  - 17: nori x17,x14,1 → 0xfffffb2c
  - 18: sw x11,0x30(x0) → 0x30
  - 19: lw x18,0x30(x0) → 0x30
  - 20: beq x0,x0,0 → 0 (halt self-loop)
- ROM words 21-63 are 0.

## Timing
- reset low: PC, and x0-x31 of the register file, clear asynchronously.
  - While reset is held, PC stays 0 and no RAM writes occur.
  - Result shows the ALU output of word 0, which is 0.
- First rising edge after reset deasserts executes word 0 and advances to word 1.
- One instruction per cycle; CPI is 1.
- Result settles combinationally within the cycle after the PC updates. Sample it just before the next rising edge.
- Register and RAM writes commit on the same edge that advances the PC, so the next instruction sees the new values with no hazards.
- Reset mid-program:
  - PC returns to 0 immediately and the registers clear.
  - RAM retains its contents.
  - Execution restarts at word 0 after release.
- From word 20 onward, PC holds at 0x50 and Result stays 0 indefinitely.

## Test plan
- Reset: hold reset low for 2 cycles → PC=0, Result=0, all registers read 0.
- Full program: release reset and sample Result before each of the next 20 edges → exact sequence 0,1,2,4,5,7,8,0xb,3,0xfffffffe,0,5,1,0xfffffff4,0x4d2,0xfffff8d7,1,0xfffffb2c,0x30,0x30 (20/20 matches).
- Store/load round trip: after word 19 executes → x18=5 and RAM word 12 = 5.
- x0 protection: after word 0 → x0 still reads 0; word 10 computes with x9=-2 and yields 0.
- Halt: run 10 extra cycles after word 20 → PC stays 0x50, Result stays 0, no register or RAM changes.
- Mid-run reset: assert reset at word 9 → Result is 0 immediately and the registers are cleared. After release the sequence replays from 0, and RAM word 12 still holds 5 before word 18 re-executes.
